rmii_frame_rx: RTL and testbench
================================

// Module: rmii_frame_rx
// PURPOSE
// Parametrised RMII receive front end for the Ethernet debug link on the Nexys A7, running on the 50 MHz ethclk.
// - Assembles RMII dibits into bytes and hunts preamble/SFD.
// - Filters frames on destination MAC and EtherType, checks CRC-32 FCS, and streams payload bytes with the FCS stripped.
// - Sits between the PHY pins and the Manta bridge; reports per-frame status and counts drops.
// PARAMETERS
// MAC_ADDR      48'h69_69_5A_06_54_91  accepted destination MAC (broadcast FF:FF:FF:FF:FF:FF always accepted)
// ETHERTYPE     16'h88B5               accepted EtherType; frames with any other value are dropped
// CHECK_FCS     1                      1: fcs_ok_o reflects the CRC check; 0: fcs_ok_o forced 1
// MAX_PAYLOAD   1500                   maximum payload bytes emitted; any excess bytes flag an error
// CNT_W         16                     width of drop_count_o
// PORTS
// clk           in   1      50 MHz RMII reference clock, also driven to eth_refclk
// rst           in   1      synchronous, active-high reset
// crsdv         in   1      RMII CRS_DV
// rxd           in   2      RMII receive dibit
// data_o        out  8      payload byte
// valid_o       out  1      data_o valid (one-cycle strobe, at most once every 4 cycles)
// done_o        out  1      one-cycle end-of-frame strobe for an accepted frame
// fcs_ok_o      out  1      qualified by done_o: FCS correct and length within limits
// drop_count_o  out  CNT_W  frames dropped (filter miss or runt); saturates at all-ones
// BEHAVIOUR
// - Reset: data_o=0, valid_o=0, done_o=0, fcs_ok_o=0, drop_count_o=0; state=WAIT_IDLE. Reset mid-frame discards that frame with no done_o.
// - Dibit order: LSB first; byte = {d3,d2,d1,d0}.
// - End of frame: crsdv low on 2 consecutive cycles. A single-cycle low (CRS/DV toggling) is not an end; its rxd is still sampled.
// - States:
//   - WAIT_IDLE: wait for crsdv low for 2 cycles, then -> HUNT.
//   - HUNT: crsdv=1 and rxd=01 -> PREAMBLE; otherwise stay.
//   - PREAMBLE: rxd=01 stays; rxd=11 (SFD tail) -> HEADER with byte phase 0 aligned; any other dibit, or end of frame -> WAIT_IDLE.
//   - HEADER: collect 14 bytes (dst MAC, src MAC, EtherType, network order). At byte 14:
//     - match on MAC and EtherType -> PAYLOAD;
//     - mismatch -> DROP, increment drop_count_o.
//     - End of frame in HEADER counts as a runt: increment drop_count_o, -> HUNT.
//   - PAYLOAD: each received byte enters a 4-byte delay line. When the line is full, the oldest byte is emitted on data_o with valid_o, the cycle the new byte completes. The last 4 bytes of the frame (FCS) are never emitted.
//     - On end of frame: done_o pulses 1 cycle later -> HUNT.
//     - Fewer than 4 payload+FCS bytes: treated as a runt: no done_o, drop_count_o++.
//   - DROP: ignore data until end of frame -> HUNT.
// - Payload length: if emitted bytes reach MAX_PAYLOAD, further bytes are not emitted, the frame continues to be consumed, and fcs_ok_o=0 at done_o.
// - Trailing partial byte (dibits not a multiple of 4) at end: discarded; fcs_ok_o=0.
// - CRC-32: reflected poly 0xEDB88320, init 0xFFFFFFFF, updated per dibit from first dst-MAC byte through FCS. Good frame iff residue == 0xDEBB20E3.
// - Latency: first payload byte valid_o 4 byte-times after it arrives (16 clk + 1 register).
// - drop_count_o saturates at 2^CNT_W-1; no wrap.
// - done_o and valid_o never assert in the same cycle.
// TESTING
// - Reset check: assert rst for 3 cycles mid-frame -> all outputs 0; no done_o for that frame; the next good frame is received normally.
// - Good frame: dst MAC_ADDR, EtherType 88B5, payload 00..2D (46 B), valid FCS -> 46 valid_o strobes with data 00..2D in order, done_o with fcs_ok_o=1.
// - Corrupt FCS: same frame with payload byte 10 flipped to 0xEF -> 46 bytes emitted, done_o with fcs_ok_o=0.
// - Filter misses: one frame with EtherType 0800 and one with dst 02:00:00:00:00:01 -> no valid_o, no done_o, drop_count_o=2.
// - Toggling CRS_DV: crsdv low on alternate cycles during the last 8 dibits -> all bytes are still received, and the frame ends only after 2 low cycles.
// - Oversize and saturation: MAX_PAYLOAD=8 with 12 payload bytes -> 8 valid_o, then fcs_ok_o=0. CNT_W=2 with 5 runts -> drop_count_o=3.

Source files
------------

// File: rtl/rmii_frame_rx.sv
// rtl/rmii_frame_rx.sv - RMII receive front end: preamble hunt, MAC/EtherType filter, FCS check, payload stream
//
// Ports:
//   clk           50 MHz RMII reference clock
//   rst           synchronous active-high reset
//   crsdv         RMII CRS_DV
//   rxd[1:0]      RMII receive dibit, LSB-first within each byte
//   data_o[7:0]   payload byte (FCS stripped)
//   valid_o       one-cycle strobe qualifying data_o
//   done_o        one-cycle end-of-frame strobe for an accepted frame
//   fcs_ok_o      qualified by done_o: FCS correct, length within limits, whole bytes only
//   drop_count_o  saturating count of filtered frames and runts

module rmii_frame_rx #(
    parameter logic [47:0] MAC_ADDR    = 48'h69_69_5A_06_54_91,
    parameter logic [15:0] ETHERTYPE   = 16'h88B5,
    parameter bit          CHECK_FCS   = 1'b1,
    parameter int          MAX_PAYLOAD = 1500,
    parameter int          CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             crsdv,
    input  logic [1:0]       rxd,
    output logic [7:0]       data_o,
    output logic             valid_o,
    output logic             done_o,
    output logic             fcs_ok_o,
    output logic [CNT_W-1:0] drop_count_o
);

    localparam int             EW       = $clog2(MAX_PAYLOAD + 1);
    localparam logic [EW-1:0]  MAXP     = EW'(MAX_PAYLOAD);
    localparam logic [31:0]    RESIDUE  = 32'hDEBB20E3;
    localparam logic [47:0]    BCAST    = 48'hFFFF_FFFF_FFFF;

    typedef enum logic [2:0] {
        WAIT_IDLE,
        HUNT,
        PREAMBLE,
        HEADER,
        PAYLOAD,
        DROP
    } state_t;

    state_t      state;

    // Inputs are processed one cycle late so that a single low CRS_DV cycle
    // can still have its dibit accepted once the following cycle shows CRS_DV
    // high again, while the first low cycle of a real end is discarded.
    logic        dv_q;
    logic [1:0]  rxd_q;

    logic [1:0]  ph;          // dibit position within the current byte
    logic [5:0]  sr;          // three previously received dibits of the current byte
    logic [3:0]  hcnt;        // header byte index
    logic [47:0] dst_sr;      // destination MAC, network order
    logic [7:0]  et_hi;       // EtherType high byte
    logic [7:0]  dl [4];      // payload delay line, dl[0] newest; holds back the FCS
    logic [2:0]  fill;        // number of valid bytes in the delay line (0..4)
    logic [EW-1:0] ecnt;      // payload bytes emitted this frame
    logic        oversize;
    logic [31:0] crc;

    logic        eof;
    logic        dib;
    logic        byte_done;
    logic [7:0]  new_byte;
    logic        hdr_match;
    logic        drop_inc;

    function automatic logic [31:0] crc_dibit(input logic [31:0] c, input logic [1:0] d);
        logic [31:0] r;
        r = c;
        for (int k = 0; k < 2; k++) begin
            r = (r[0] ^ d[k]) ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
        end
        return r;
    endfunction

    always_comb begin
        eof       = !dv_q && !crsdv;
        dib       = dv_q || crsdv;
        byte_done = dib && (ph == 2'd3);
        new_byte  = {rxd_q, sr};
        hdr_match = ((dst_sr == MAC_ADDR) || (dst_sr == BCAST))
                    && ({et_hi, new_byte} == ETHERTYPE);
        drop_inc  = 1'b0;
        if (state == HEADER) begin
            if (eof) begin
                drop_inc = 1'b1;
            end else if (byte_done && hcnt == 4'd13 && !hdr_match) begin
                drop_inc = 1'b1;
            end
        end else if (state == PAYLOAD && eof && fill != 3'd4) begin
            drop_inc = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= WAIT_IDLE;
            dv_q         <= 1'b0;
            rxd_q        <= 2'b00;
            ph           <= 2'd0;
            sr           <= 6'd0;
            hcnt         <= 4'd0;
            dst_sr       <= 48'd0;
            et_hi        <= 8'd0;
            for (int i = 0; i < 4; i++) begin
                dl[i] <= 8'd0;
            end
            fill         <= 3'd0;
            ecnt         <= '0;
            oversize     <= 1'b0;
            crc          <= 32'hFFFF_FFFF;
            data_o       <= 8'd0;
            valid_o      <= 1'b0;
            done_o       <= 1'b0;
            fcs_ok_o     <= 1'b0;
            drop_count_o <= '0;
        end else begin
            dv_q    <= crsdv;
            rxd_q   <= rxd;
            valid_o <= 1'b0;
            done_o  <= 1'b0;

            if (drop_inc && drop_count_o != {CNT_W{1'b1}}) begin
                drop_count_o <= drop_count_o + 1'b1;
            end

            // Byte assembly and CRC run on every accepted dibit; the SFD
            // transition below re-aligns the phase and re-seeds the CRC.
            if (dib) begin
                sr  <= {rxd_q, sr[5:2]};
                ph  <= ph + 2'd1;
                crc <= crc_dibit(crc, rxd_q);
            end

            case (state)
                WAIT_IDLE: begin
                    if (eof) begin
                        state <= HUNT;
                    end
                end

                HUNT: begin
                    if (dib && rxd_q == 2'b01) begin
                        state <= PREAMBLE;
                    end
                end

                PREAMBLE: begin
                    if (eof) begin
                        state <= WAIT_IDLE;
                    end else if (dib) begin
                        if (rxd_q == 2'b11) begin
                            state <= HEADER;
                            ph    <= 2'd0;
                            crc   <= 32'hFFFF_FFFF;
                            hcnt  <= 4'd0;
                        end else if (rxd_q != 2'b01) begin
                            state <= WAIT_IDLE;
                        end
                    end
                end

                HEADER: begin
                    if (eof) begin
                        state <= HUNT;
                    end else if (byte_done) begin
                        hcnt <= hcnt + 4'd1;
                        if (hcnt < 4'd6) begin
                            dst_sr <= {dst_sr[39:0], new_byte};
                        end
                        if (hcnt == 4'd12) begin
                            et_hi <= new_byte;
                        end
                        if (hcnt == 4'd13) begin
                            state    <= hdr_match ? PAYLOAD : DROP;
                            fill     <= 3'd0;
                            ecnt     <= '0;
                            oversize <= 1'b0;
                        end
                    end
                end

                PAYLOAD: begin
                    if (eof) begin
                        state <= HUNT;
                        if (fill == 3'd4) begin
                            done_o   <= 1'b1;
                            fcs_ok_o <= CHECK_FCS ? ((crc == RESIDUE) && !oversize && ph == 2'd0)
                                                  : 1'b1;
                        end
                    end else if (byte_done) begin
                        dl[0] <= new_byte;
                        dl[1] <= dl[0];
                        dl[2] <= dl[1];
                        dl[3] <= dl[2];
                        if (fill == 3'd4) begin
                            // Oldest byte is known not to be FCS once a newer one arrives.
                            if (ecnt < MAXP) begin
                                data_o  <= dl[3];
                                valid_o <= 1'b1;
                                ecnt    <= ecnt + 1'b1;
                            end else begin
                                oversize <= 1'b1;
                            end
                        end else begin
                            fill <= fill + 3'd1;
                        end
                    end
                end

                DROP: begin
                    if (eof) begin
                        state <= HUNT;
                    end
                end

                default: state <= WAIT_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rmii_frame_rx.sv
// tb/tb_rmii_frame_rx.sv - self-checking bench for rmii_frame_rx
module tb_rmii_frame_rx;

    localparam logic [47:0] MAC = 48'h69_69_5A_06_54_91;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        crsdv_a = 1'b0, crsdv_b = 1'b0;
    logic [1:0]  rxd_a = 2'b00, rxd_b = 2'b00;
    logic [7:0]  data_a, data_b;
    logic        valid_a, valid_b, done_a, done_b, fcs_ok_a, fcs_ok_b;
    logic [15:0] drop_a;
    logic [1:0]  drop_b;

    always #10 clk = ~clk;

    rmii_frame_rx u_a (
        .clk(clk), .rst(rst), .crsdv(crsdv_a), .rxd(rxd_a),
        .data_o(data_a), .valid_o(valid_a), .done_o(done_a),
        .fcs_ok_o(fcs_ok_a), .drop_count_o(drop_a)
    );

    rmii_frame_rx #(.MAX_PAYLOAD(8), .CNT_W(2)) u_b (
        .clk(clk), .rst(rst), .crsdv(crsdv_b), .rxd(rxd_b),
        .data_o(data_b), .valid_o(valid_b), .done_o(done_b),
        .fcs_ok_o(fcs_ok_b), .drop_count_o(drop_b)
    );

    int checks = 0;
    int errors = 0;
    logic [7:0] frm[$];
    logic [7:0] exp_a[$];
    logic [7:0] exp_b[$];
    int   vcnt_a = 0, vcnt_b = 0, dcnt_a = 0, dcnt_b = 0;
    logic last_fcs_a = 1'b0, last_fcs_b = 1'b0;
    logic [7:0]  snap_data;
    logic        snap_valid, snap_done, snap_fcs;
    logic [15:0] snap_drop;

    // Scoreboard: every payload strobe pops the next expected byte.
    always @(negedge clk) begin
        logic [7:0] e;
        if (valid_a) begin
            vcnt_a++;
            checks++;
            if (exp_a.size() == 0) begin
                errors++;
                $display("FAIL a_byte: got %02h, expected no byte", data_a);
            end else begin
                e = exp_a.pop_front();
                if (data_a !== e) begin
                    errors++;
                    $display("FAIL a_byte: got %02h, expected %02h", data_a, e);
                end
            end
        end
        if (valid_b) begin
            vcnt_b++;
            checks++;
            if (exp_b.size() == 0) begin
                errors++;
                $display("FAIL b_byte: got %02h, expected no byte", data_b);
            end else begin
                e = exp_b.pop_front();
                if (data_b !== e) begin
                    errors++;
                    $display("FAIL b_byte: got %02h, expected %02h", data_b, e);
                end
            end
        end
        if (done_a) begin dcnt_a++; last_fcs_a = fcs_ok_a; end
        if (done_b) begin dcnt_b++; last_fcs_b = fcs_ok_b; end
        if ((valid_a && done_a) || (valid_b && done_b)) begin
            checks++;
            errors++;
            $display("FAIL valid_done_overlap: got both 1, expected not both");
        end
    end

    function automatic logic [31:0] fcs_of_frm();
        logic [31:0] c;
        c = 32'hFFFF_FFFF;
        foreach (frm[i]) begin
            c = c ^ {24'h0, frm[i]};
            for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
        end
        return ~c;
    endfunction

    // dst/etype header, payload 0..n-1, FCS; optional corruption after FCS;
    // push = 1/2 queues the first maxp payload bytes for DUT a/b.
    task automatic build_frame(input logic [47:0] dst, input logic [15:0] et, input int n,
                               input int bad_idx, input int push, input int maxp);
        logic [31:0] f;
        frm = {};
        for (int i = 0; i < 6; i++) frm.push_back(dst[47-8*i -: 8]);
        for (int i = 0; i < 6; i++) frm.push_back((i == 5) ? 8'hAA : ((i == 0) ? 8'h02 : 8'h00));
        frm.push_back(et[15:8]);
        frm.push_back(et[7:0]);
        for (int i = 0; i < n; i++) frm.push_back(8'(i));
        f = fcs_of_frm();
        for (int i = 0; i < 4; i++) frm.push_back(f[8*i +: 8]);
        if (bad_idx >= 0) frm[14 + bad_idx] = 8'hEF;
        for (int i = 0; i < n && i < maxp; i++) begin
            if (push == 1) exp_a.push_back(frm[14 + i]);
            if (push == 2) exp_b.push_back(frm[14 + i]);
        end
    endtask

    task automatic set_line(input bit sel, input logic dv, input logic [1:0] d);
        if (sel) begin crsdv_b = dv; rxd_b = d; end
        else     begin crsdv_a = dv; rxd_a = d; end
    endtask

    task automatic drive(input bit sel, input bit toggle, input int rst_at, input int extra);
        logic [7:0] wb[$];
        logic [7:0] b;
        logic [1:0] d;
        logic       dv;
        int         nd;
        int         nb;
        wb = {};
        for (int i = 0; i < 7; i++) wb.push_back(8'h55);
        wb.push_back(8'hD5);
        foreach (frm[i]) wb.push_back(frm[i]);
        nb = wb.size() * 4;
        nd = nb + extra;
        set_line(sel, 1'b0, 2'b00);
        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < nd; i++) begin
            d = 2'b00;
            if (i < nb) begin
                b = wb[i/4];
                d = b[2*(i%4) +: 2];
            end
            dv = !(toggle && i >= nd - 8 && ((nd - 1 - i) % 2 == 1));
            if (i == rst_at) rst = 1'b1;
            if (i == rst_at + 3) rst = 1'b0;
            set_line(sel, dv, d);
            @(posedge clk);
            #1;
            if (i == rst_at + 1) begin
                snap_data = data_a; snap_valid = valid_a; snap_done = done_a;
                snap_fcs = fcs_ok_a; snap_drop = drop_a;
            end
        end
        set_line(sel, 1'b0, 2'b00);
        repeat (6) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (data_a !== 8'h00) begin errors++; $display("FAIL reset_data: got %02h, expected 00", data_a); end
        checks++; if (valid_a !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b, expected 0", valid_a); end
        checks++; if (done_a !== 1'b0) begin errors++; $display("FAIL reset_done: got %b, expected 0", done_a); end
        checks++; if (fcs_ok_a !== 1'b0) begin errors++; $display("FAIL reset_fcs_ok: got %b, expected 0", fcs_ok_a); end
        checks++; if (drop_a !== 16'd0) begin errors++; $display("FAIL reset_drop: got %0d, expected 0", drop_a); end
        rst = 1'b0;
    endtask

    task automatic test_frame(input string name, input logic [47:0] dst, input int bad_idx,
                              input bit toggle, input int extra, input logic exp_fcs);
        int v0, d0;
        build_frame(dst, 16'h88B5, 46, bad_idx, 1, 1500);
        v0 = vcnt_a; d0 = dcnt_a;
        drive(1'b0, toggle, -10, extra);
        checks++; if (vcnt_a - v0 != 46) begin errors++; $display("FAIL %s_count: got %0d, expected 46", name, vcnt_a - v0); end
        checks++; if (exp_a.size() != 0) begin errors++; $display("FAIL %s_left: got %0d, expected 0", name, exp_a.size()); end
        checks++; if (dcnt_a - d0 != 1) begin errors++; $display("FAIL %s_done: got %0d, expected 1", name, dcnt_a - d0); end
        checks++; if (last_fcs_a !== exp_fcs) begin errors++; $display("FAIL %s_fcs_ok: got %b, expected %b", name, last_fcs_a, exp_fcs); end
        exp_a = {};
    endtask

    task automatic test_filter();
        int v0, d0;
        v0 = vcnt_a; d0 = dcnt_a;
        build_frame(MAC, 16'h0800, 46, -1, 0, 0);
        drive(1'b0, 1'b0, -10, 0);
        build_frame(48'h02_00_00_00_00_01, 16'h88B5, 46, -1, 0, 0);
        drive(1'b0, 1'b0, -10, 0);
        checks++; if (vcnt_a != v0) begin errors++; $display("FAIL filter_valid: got %0d, expected %0d", vcnt_a, v0); end
        checks++; if (dcnt_a != d0) begin errors++; $display("FAIL filter_done: got %0d, expected %0d", dcnt_a, d0); end
        checks++; if (drop_a !== 16'd2) begin errors++; $display("FAIL filter_drop: got %0d, expected 2", drop_a); end
    endtask

    task automatic test_reset_midframe();
        int d0;
        build_frame(MAC, 16'h88B5, 46, -1, 0, 0);
        d0 = dcnt_a;
        drive(1'b0, 1'b0, 100, 0);
        checks++; if (snap_data !== 8'h00) begin errors++; $display("FAIL rst_mid_data: got %02h, expected 00", snap_data); end
        checks++; if (snap_valid !== 1'b0 || snap_done !== 1'b0) begin errors++; $display("FAIL rst_mid_strobes: got %b%b, expected 00", snap_valid, snap_done); end
        checks++; if (snap_fcs !== 1'b0) begin errors++; $display("FAIL rst_mid_fcs_ok: got %b, expected 0", snap_fcs); end
        checks++; if (snap_drop !== 16'd0) begin errors++; $display("FAIL rst_mid_drop: got %0d, expected 0", snap_drop); end
        checks++; if (dcnt_a != d0) begin errors++; $display("FAIL rst_mid_done: got %0d, expected %0d", dcnt_a, d0); end
        test_frame("after_reset", MAC, -1, 1'b0, 0, 1'b1);
    endtask

    task automatic test_payload_runt();
        int d0;
        d0 = dcnt_a;
        build_frame(MAC, 16'h88B5, 46, -1, 0, 0);
        while (frm.size() > 17) void'(frm.pop_back());
        drive(1'b0, 1'b0, -10, 0);
        checks++; if (dcnt_a != d0) begin errors++; $display("FAIL prunt_done: got %0d, expected %0d", dcnt_a, d0); end
        checks++; if (drop_a !== 16'd1) begin errors++; $display("FAIL prunt_drop: got %0d, expected 1", drop_a); end
    endtask

    task automatic test_oversize(input int n, input logic exp_fcs);
        int v0, d0;
        build_frame(MAC, 16'h88B5, n, -1, 2, 8);
        v0 = vcnt_b; d0 = dcnt_b;
        drive(1'b1, 1'b0, -10, 0);
        checks++; if (vcnt_b - v0 != 8) begin errors++; $display("FAIL oversize_%0d_count: got %0d, expected 8", n, vcnt_b - v0); end
        checks++; if (dcnt_b - d0 != 1) begin errors++; $display("FAIL oversize_%0d_done: got %0d, expected 1", n, dcnt_b - d0); end
        checks++; if (last_fcs_b !== exp_fcs) begin errors++; $display("FAIL oversize_%0d_fcs_ok: got %b, expected %b", n, last_fcs_b, exp_fcs); end
        exp_b = {};
    endtask

    task automatic test_saturation();
        for (int r = 0; r < 5; r++) begin
            build_frame(MAC, 16'h88B5, 0, -1, 0, 0);
            while (frm.size() > 6) void'(frm.pop_back());
            drive(1'b1, 1'b0, -10, 0);
            if (r == 0) begin
                checks++; if (drop_b !== 2'd1) begin errors++; $display("FAIL sat_first: got %0d, expected 1", drop_b); end
            end
        end
        checks++; if (drop_b !== 2'd3) begin errors++; $display("FAIL sat_final: got %0d, expected 3", drop_b); end
    endtask

    initial begin
        test_reset();
        test_frame("bad_fcs", MAC, 10, 1'b0, 0, 1'b0);
        test_filter();
        test_frame("good", MAC, -1, 1'b0, 0, 1'b1);
        test_reset_midframe();
        test_frame("toggle", MAC, -1, 1'b1, 0, 1'b1);
        test_frame("broadcast", 48'hFFFF_FFFF_FFFF, -1, 1'b0, 0, 1'b1);
        test_frame("partial", MAC, -1, 1'b0, 2, 1'b0);
        test_payload_runt();
        test_oversize(8, 1'b1);
        test_oversize(12, 1'b0);
        test_saturation();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
